// File: rtl/serdes_pkg.sv
// Shared types and default geometry for the nibble-wide serializer family.
// The FSM state encoding is shared so that related blocks decode state the same way.
package serdes_pkg;

    localparam int DEF_W       = 4;
    localparam int DEF_NIBBLES = 4;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } ser_state_t;

    typedef logic [DEF_W-1:0] nibble_t;

endpackage : serdes_pkg

// File: rtl/custom_ff.sv
// Register cell with priority reset > load > shift > hold.
// Used as one stage of a parallel-load shift chain.
module custom_ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_d,
    input  logic [W-1:0] shift_d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking (<=) so every stage samples its
    // neighbour's pre-edge value; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_d;
        end else if (shift) begin
            q <= shift_d;
        end
    end

endmodule : custom_ff

// File: rtl/nibble_serializer.sv
// Parallel-to-serial stage: takes a NIBBLES*W-bit word and emits W-bit beats,
// least-significant nibble first, over two valid/ready handshakes.
module nibble_serializer
    import serdes_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int NIBBLES = DEF_NIBBLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIBBLES*W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int              CW   = $clog2(NIBBLES);
    localparam logic [CW-1:0]   LAST = CW'(NIBBLES - 1);

    ser_state_t      state;
    logic [CW-1:0]   count;
    logic            load_en;
    logic            shift_en;
    logic [W-1:0]    stage [NIBBLES];

    // in_ready is gated by rst so a source never sees acceptance during reset.
    assign in_ready = (state == IDLE) && !rst;
    assign load_en  = in_valid && in_ready;
    assign shift_en = (state == SHIFT) && out_ready;
    assign out_data = stage[0];

    for (genvar k = 0; k < NIBBLES; k++) begin : g_chain
        logic [W-1:0] shift_src;

        if (k == NIBBLES - 1) begin : g_top
            assign shift_src = '0;
        end else begin : g_mid
            assign shift_src = stage[k+1];
        end

        custom_ff #(
            .W (W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load    (load_en),
            .shift   (shift_en),
            .load_d  (in_data[k*W +: W]),
            .shift_d (shift_src),
            .q       (stage[k])
        );
    end

    // Control FSM, beat counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en) begin
                        state     <= SHIFT;
                        count     <= '0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (count == LAST) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            count    <= count + CW'(1);
                            out_last <= ((count + CW'(1)) == LAST);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    load_shift_exclusive: assert property (@(posedge clk) !(load_en && shift_en));

endmodule : nibble_serializer

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer: per-cycle vector table on the default
// 4x4 build, then hand-written sequences for a 2x8 build and paced backpressure.
module tb_nibble_serializer;
    import serdes_pkg::*;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] data;
        logic        ordy;
        logic        e_ov;
        logic [3:0]  e_od;
        logic        e_last;
        logic        e_ir;
        logic        e_busy;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [15:0] in_data;
    logic [3:0]  out_data;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_last8, busy8;
    logic [15:0] in_data8;
    logic [7:0]  out_data8;

    int total = 0;
    int bad   = 0;

    nibble_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    nibble_serializer #(
        .W       (8),
        .NIBBLES (2)
    ) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .out_last  (out_last8),
        .busy      (busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic r, logic iv, logic [15:0] d, logic ordy,
                                logic ov, logic [3:0] od, logic l, logic ir, logic b);
        vec_t v;
        v.rst = r;  v.iv = iv; v.data = d; v.ordy = ordy;
        v.e_ov = ov; v.e_od = od; v.e_last = l; v.e_ir = ir; v.e_busy = b;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] got_word;
        int          beats;
        int          cyc;
        bit          done;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
        repeat (2) step();

        // Outputs are those seen before the edge at which the listed inputs are sampled.
        //                   rst iv  data      ordy  ov od    last ir busy
        vecs.push_back(mk(1, 0, 16'h0000, 1,  0, 4'h0, 0, 0, 0)); // in reset
        vecs.push_back(mk(0, 1, 16'hA5C3, 1,  0, 4'h0, 0, 1, 0)); // accept
        vecs.push_back(mk(0, 0, 16'hA5C3, 1,  1, 4'h3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'hA5C3, 1,  1, 4'hC, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'hA5C3, 1,  1, 4'h5, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'hA5C3, 1,  1, 4'hA, 1, 0, 1));
        vecs.push_back(mk(0, 1, 16'hA5C3, 1,  0, 4'h0, 0, 1, 0)); // idle, accept again
        vecs.push_back(mk(0, 0, 16'hA5C3, 1,  1, 4'h3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'hA5C3, 0,  1, 4'hC, 0, 0, 1)); // stall x3 on beat 1
        vecs.push_back(mk(0, 0, 16'hA5C3, 0,  1, 4'hC, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'hA5C3, 0,  1, 4'hC, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'hA5C3, 1,  1, 4'hC, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'hA5C3, 1,  1, 4'h5, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'hA5C3, 1,  1, 4'hA, 1, 0, 1));
        vecs.push_back(mk(0, 1, 16'hA5C3, 1,  0, 4'h0, 0, 1, 0)); // accept, then 1234 waits
        vecs.push_back(mk(0, 1, 16'h1234, 1,  1, 4'h3, 0, 0, 1));
        vecs.push_back(mk(0, 1, 16'h1234, 1,  1, 4'hC, 0, 0, 1));
        vecs.push_back(mk(0, 1, 16'h1234, 1,  1, 4'h5, 0, 0, 1));
        vecs.push_back(mk(0, 1, 16'h1234, 1,  1, 4'hA, 1, 0, 1));
        vecs.push_back(mk(0, 1, 16'h1234, 1,  0, 4'h0, 0, 1, 0)); // 1234 accepted
        vecs.push_back(mk(0, 0, 16'h1234, 1,  1, 4'h4, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h1234, 1,  1, 4'h3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h1234, 1,  1, 4'h2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h1234, 1,  1, 4'h1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 16'h8421, 1,  0, 4'h0, 0, 1, 0)); // accept 8421
        vecs.push_back(mk(0, 0, 16'h0000, 1,  1, 4'h1, 0, 0, 1)); // input changed after accept
        vecs.push_back(mk(0, 0, 16'h0000, 1,  1, 4'h2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1,  1, 4'h4, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1,  1, 4'h8, 1, 0, 1));
        vecs.push_back(mk(0, 1, 16'hFFFF, 1,  0, 4'h0, 0, 1, 0)); // accept FFFF
        vecs.push_back(mk(0, 0, 16'hFFFF, 1,  1, 4'hF, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'hFFFF, 1,  1, 4'hF, 0, 0, 1));
        vecs.push_back(mk(1, 0, 16'hFFFF, 1,  1, 4'hF, 0, 0, 1)); // reset mid-word
        vecs.push_back(mk(0, 1, 16'h0F0F, 1,  0, 4'h0, 0, 1, 0)); // flushed, accept 0F0F
        vecs.push_back(mk(0, 0, 16'h0F0F, 1,  1, 4'hF, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0F0F, 1,  1, 4'h0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0F0F, 1,  1, 4'hF, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0F0F, 1,  1, 4'h0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0F0F, 1,  0, 4'h0, 0, 1, 0));

        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].data;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d out_data",  i), 32'(out_data),  32'(vecs[i].e_od));
            check($sformatf("v%0d out_last",  i), 32'(out_last),  32'(vecs[i].e_last));
            check($sformatf("v%0d in_ready",  i), 32'(in_ready),  32'(vecs[i].e_ir));
            check($sformatf("v%0d busy",      i), 32'(busy),      32'(vecs[i].e_busy));
            step();
        end
        in_valid = 1'b0;

        // Two-beat, byte-wide build: BEEF -> EF then BE (last).
        in_valid8 = 1'b1; in_data8 = 16'hBEEF; out_ready8 = 1'b1;
        #1;
        check("w8 in_ready idle", 32'(in_ready8), 32'd1);
        step();
        in_valid8 = 1'b0; in_data8 = 16'h0000;
        check("w8 beat0 valid", 32'(out_valid8), 32'd1);
        check("w8 beat0 data",  32'(out_data8),  32'hEF);
        check("w8 beat0 last",  32'(out_last8),  32'd0);
        step();
        check("w8 beat1 data",  32'(out_data8),  32'hBE);
        check("w8 beat1 last",  32'(out_last8),  32'd1);
        step();
        check("w8 idle valid",  32'(out_valid8), 32'd0);
        check("w8 idle ready",  32'(in_ready8),  32'd1);

        // Paced sink: reassemble 9C6E from beats under a bounded cycle budget.
        in_valid = 1'b1; in_data = 16'h9C6E; out_ready = 1'b0;
        #1;
        check("paced accept ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; in_data = 16'h0000;
        got_word = '0; beats = 0; done = 1'b0;
        for (cyc = 0; cyc < 40 && !done; cyc++) begin
            out_ready = (cyc % 3) != 0;
            #1;
            if (out_valid && out_ready) begin
                if (beats < 4) got_word[beats*4 +: 4] = out_data;
                beats++;
                if (out_last) done = 1'b1;
            end
            step();
        end
        check("paced finished in budget", 32'(done), 32'd1);
        check("paced beat count", 32'(beats), 32'd4);
        check("paced word", 32'(got_word), 32'h9C6E);
        check("paced back to idle", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_nibble_serializer
